// File: rtl/bpsk_pkg.sv
// Shared types for the BPSK demodulator sequencer.
// State encoding and bit-rate codes.
package bpsk_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PASS    = 3'd1,
    FLUSH   = 3'd2,
    SETTLE  = 3'd3,
    ACQUIRE = 3'd4,
    LOCKED  = 3'd5,
    ERROR   = 3'd6
  } state_t;

  localparam logic [7:0] RATE_6K  = 8'd6;
  localparam logic [7:0] RATE_8K  = 8'd8;
  localparam logic [7:0] RATE_10K = 8'd10;

  localparam logic [3:0] RELOCK_MAX = 4'd15;

endpackage

// File: rtl/bpsk_demod_seq_if.sv
// Control/status bundle between the UI logic,
// the demodulator and the run-time sequencer.
interface bpsk_demod_seq_if;
  import bpsk_pkg::*;

  logic       start;
  logic       stop;
  logic       mode_req;
  logic [7:0] freq_in;
  logic       code_edge;
  logic       demod_en;
  logic       demod_mode;
  logic       demod_clr;
  logic [7:0] freq_out;
  logic       freq_valid;
  logic       timeout_err;
  logic [3:0] relock_cnt;
  state_t     state;

  modport master (
    output start, stop, mode_req,
    output freq_in, code_edge,
    input  demod_en, demod_mode, demod_clr,
    input  freq_out, freq_valid,
    input  timeout_err, relock_cnt, state
  );

  modport slave (
    input  start, stop, mode_req,
    input  freq_in, code_edge,
    output demod_en, demod_mode, demod_clr,
    output freq_out, freq_valid,
    output timeout_err, relock_cnt, state
  );

endinterface

// File: rtl/bpsk_lock_qual.sv
// Bit-rate qualifier: periodic sampling of freq_in,
// candidate match counting and acquisition timeout.
module bpsk_lock_qual #(
  parameter int SAMPLE_CYC  = 3200,
  parameter int LOCK_CNT    = 4,
  parameter int ACQ_TIMEOUT = 200
) (
  input  logic       clk_32m,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       run,
  input  logic [7:0] freq_in,
  output logic       lock,
  output logic [7:0] lock_val,
  output logic       timeout
);

  localparam int SW = $clog2(SAMPLE_CYC + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int TW = $clog2(ACQ_TIMEOUT + 1);

  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_CYC - 1);
  localparam logic [MW-1:0] M_LOCK = MW'(LOCK_CNT);
  localparam logic [TW-1:0] T_LAST = TW'(ACQ_TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(ACQ_TIMEOUT);

  logic [SW-1:0] samp_cnt;
  logic [MW-1:0] match_cnt;
  logic [MW-1:0] match_nxt;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    cand;
  logic [7:0]    cand_nxt;
  logic          tick;

  assign tick = run && (samp_cnt == S_LAST);

  always_comb begin
    cand_nxt  = cand;
    match_nxt = match_cnt;
    if (freq_in == 8'd0) begin
      match_nxt = '0;
    end else if (freq_in == cand) begin
      if (match_cnt != M_LOCK)
        match_nxt = match_cnt + 1'b1;
    end else begin
      cand_nxt  = freq_in;
      match_nxt = MW'(1);
    end
  end

  // Lock is decided on the tick itself so the
  // sequencer can leave ACQUIRE on that edge.
  assign lock     = tick && (match_nxt == M_LOCK);
  assign lock_val = cand_nxt;
  assign timeout  = tick && (tick_cnt == T_LAST);

  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt  <= '0;
      match_cnt <= '0;
      tick_cnt  <= '0;
      cand      <= '0;
    end else if (clear) begin
      samp_cnt  <= '0;
      match_cnt <= '0;
      tick_cnt  <= '0;
      cand      <= '0;
    end else if (run) begin
      samp_cnt <= tick ? '0 : samp_cnt + 1'b1;
      if (tick) begin
        cand      <= cand_nxt;
        match_cnt <= match_nxt;
        if (tick_cnt != T_MAX)
          tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bpsk_demod_seq.sv
// Run-time sequencer for the BPSK demodulator:
// flush/settle/acquire/lock with loss re-acquisition.
module bpsk_demod_seq
  import bpsk_pkg::*;
#(
  parameter int FLUSH_CYC   = 16,
  parameter int SETTLE_CYC  = 32000,
  parameter int SAMPLE_CYC  = 3200,
  parameter int LOCK_CNT    = 4,
  parameter int ACQ_TIMEOUT = 200,
  parameter int LOSS_CYC    = 16000
) (
  input  logic             clk_32m,
  input  logic             rst_n,
  bpsk_demod_seq_if.slave  bus
);

  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int LW = $clog2(LOSS_CYC + 1);

  localparam logic [FW-1:0] F_LAST = FW'(FLUSH_CYC - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LOSS_CYC - 1);

  state_t        state_q;
  state_t        state_d;
  logic [FW-1:0] flush_cnt;
  logic [SW-1:0] settle_cnt;
  logic [LW-1:0] loss_tmr;
  logic          flush_done;
  logic          settle_done;
  logic          loss;
  logic          relock;
  logic          restart;
  logic          qual_clr;
  logic          qual_run;
  logic          q_lock;
  logic          q_timeout;
  logic [7:0]    q_val;

  assign flush_done  = flush_cnt == F_LAST;
  assign settle_done = settle_cnt == S_LAST;
  assign loss        = !bus.code_edge && (loss_tmr == L_LAST);
  assign relock      = (state_q == LOCKED) && loss &&
                       !bus.start && !bus.stop;
  assign restart     = bus.start || bus.stop ||
                       (state_d != state_q);
  assign qual_run    = state_q == ACQUIRE;
  assign qual_clr    = !qual_run;
  assign bus.state   = state_q;

  bpsk_lock_qual #(
    .SAMPLE_CYC  (SAMPLE_CYC),
    .LOCK_CNT    (LOCK_CNT),
    .ACQ_TIMEOUT (ACQ_TIMEOUT)
  ) u_qual (
    .clk_32m  (clk_32m),
    .rst_n    (rst_n),
    .clear    (qual_clr),
    .run      (qual_run),
    .freq_in  (bus.freq_in),
    .lock     (q_lock),
    .lock_val (q_val),
    .timeout  (q_timeout)
  );

  always_comb begin
    state_d = state_q;
    if (bus.stop)
      state_d = IDLE;
    else if (bus.start)
      state_d = bus.mode_req ? FLUSH : PASS;
    else begin
      unique case (state_q)
        FLUSH:   if (flush_done) state_d = SETTLE;
        SETTLE:  if (settle_done) state_d = ACQUIRE;
        ACQUIRE: begin
          if (q_lock)         state_d = LOCKED;
          else if (q_timeout) state_d = ERROR;
        end
        LOCKED:  if (loss) state_d = FLUSH;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs are decoded from the next state so they
  // change on the same edge the state is entered.
  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      flush_cnt       <= '0;
      settle_cnt      <= '0;
      loss_tmr        <= '0;
      bus.demod_en    <= 1'b0;
      bus.demod_mode  <= 1'b0;
      bus.demod_clr   <= 1'b0;
      bus.freq_out    <= '0;
      bus.freq_valid  <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.relock_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      flush_cnt  <= (restart || state_q != FLUSH) ?
                    '0 : flush_cnt + 1'b1;
      settle_cnt <= (restart || state_q != SETTLE) ?
                    '0 : settle_cnt + 1'b1;
      loss_tmr   <= (restart || state_q != LOCKED ||
                     bus.code_edge) ?
                    '0 : loss_tmr + 1'b1;

      bus.demod_en    <= state_d inside
                         {PASS, SETTLE, ACQUIRE, LOCKED};
      bus.demod_mode  <= state_d inside
                         {FLUSH, SETTLE, ACQUIRE, LOCKED};
      bus.demod_clr   <= state_d == FLUSH;
      bus.freq_valid  <= state_d == LOCKED;
      bus.timeout_err <= state_d == ERROR;

      if (state_q == ACQUIRE && state_d == LOCKED)
        bus.freq_out <= q_val;

      if (bus.start && !bus.stop)
        bus.relock_cnt <= '0;
      else if (relock && bus.relock_cnt != RELOCK_MAX)
        bus.relock_cnt <= bus.relock_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bpsk_demod_seq.sv
// Scoreboard bench for bpsk_demod_seq: expected state
// entries are queued by stimulus, checked on each change.
module tb_bpsk_demod_seq;
  import bpsk_pkg::*;

  typedef struct {
    logic [19:0] val;
    logic [19:0] mask;
    int          at;
  } exp_t;

  logic clk_32m = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  exp_t exp_q[$];

  logic [7:0] seq [5] = '{8'd6, 8'd6, 8'd8, 8'd8, 8'd8};

  bpsk_demod_seq_if bus();

  bpsk_demod_seq #(
    .FLUSH_CYC   (4),
    .SETTLE_CYC  (8),
    .SAMPLE_CYC  (10),
    .LOCK_CNT    (3),
    .ACQ_TIMEOUT (5),
    .LOSS_CYC    (50)
  ) dut (
    .clk_32m (clk_32m),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_32m = ~clk_32m;

  initial forever begin
    @(posedge clk_32m);
    cyc++;
  end

  // Expected snapshot of all outputs on entering st.
  function automatic exp_t mk(state_t st, int rl, int fo,
                              bit rs, int at);
    exp_t e;
    logic en, md, clr, vl, te, mm;
    en = 1'b0; md = 1'b0; clr = 1'b0;
    vl = 1'b0; te = 1'b0; mm = 1'b1;
    case (st)
      PASS:    en = 1'b1;
      FLUSH:   begin clr = 1'b1; mm = 1'b0; end
      SETTLE,
      ACQUIRE: begin en = 1'b1; md = 1'b1; end
      LOCKED:  begin en = 1'b1; md = 1'b1; vl = 1'b1; end
      ERROR:   begin te = 1'b1; mm = 1'b0; end
      default: mm = rs;
    endcase
    e.val  = {st, en, md, clr, vl, te, 4'(rl), 8'(fo)};
    e.mask = {3'h7, 1'b1, mm, 3'h7, 4'hf,
              (vl || rs) ? 8'hff : 8'h00};
    e.at   = at;
    return e;
  endfunction

  initial begin
    logic [2:0]  prev;
    logic [19:0] act;
    exp_t        e;
    prev = 3'h7;
    forever begin
      @(negedge clk_32m);
      if (bus.state != prev) begin
        prev = bus.state;
        act  = {bus.state, bus.demod_en, bus.demod_mode,
                bus.demod_clr, bus.freq_valid,
                bus.timeout_err, bus.relock_cnt,
                bus.freq_out};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_state: got state=%0d at cyc %0d, required no change",
                   prev, cyc);
        end else begin
          e = exp_q.pop_front();
          if (((act ^ e.val) & e.mask) != 20'h0 ||
              (e.at >= 0 && e.at != cyc)) begin
            bad++;
            $display("FAIL state_entry: got %05h at cyc %0d, required %05h (mask %05h) at cyc %0d",
                     act, cyc, e.val, e.mask, e.at);
          end
        end
      end
    end
  end

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk_32m);
  endtask

  task automatic pulse_start(logic m);
    bus.mode_req = m;
    bus.start    = 1'b1;
    @(negedge clk_32m);
    bus.start    = 1'b0;
  endtask

  task automatic do_stop(int rl);
    exp_q.push_back(mk(IDLE, rl, 0, 1'b0, cyc + 1));
    bus.stop = 1'b1;
    @(negedge clk_32m);
    bus.stop = 1'b0;
  endtask

  task automatic push_acq(int p, int rl);
    exp_q.push_back(mk(FLUSH, rl, 0, 1'b0, p));
    exp_q.push_back(mk(SETTLE, rl, 0, 1'b0, p + 4));
    exp_q.push_back(mk(ACQUIRE, rl, 0, 1'b0, p + 12));
  endtask

  initial begin
    int p;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mode_req  = 1'b0;
    bus.freq_in   = 8'd0;
    bus.code_edge = 1'b0;
    exp_q.push_back(mk(IDLE, 0, 0, 1'b1, -1));
    repeat (3) @(negedge clk_32m);
    rst_n = 1'b1;
    @(negedge clk_32m);

    // constant 8 kbps with regular code edges
    bus.freq_in = RATE_8K;
    p = cyc + 1;
    push_acq(p, 0);
    exp_q.push_back(mk(LOCKED, 0, 8, 1'b0, p + 42));
    pulse_start(1'b1);
    while (cyc < p + 170) begin
      bus.code_edge = ((cyc - p) % 20) == 0;
      @(negedge clk_32m);
    end
    bus.code_edge = 1'b0;
    do_stop(0);

    // candidate changes, lock on the timeout tick
    bus.freq_in = seq[0];
    p = cyc + 1;
    push_acq(p, 0);
    exp_q.push_back(mk(LOCKED, 0, 8, 1'b0, p + 62));
    pulse_start(1'b1);
    for (int k = 0; k < 5; k++) begin
      bus.freq_in = seq[k];
      wait_cyc(p + 22 + 10 * k);
    end
    wait_cyc(p + 70);
    do_stop(0);

    // unknown rate -> acquisition timeout
    bus.freq_in = 8'd0;
    p = cyc + 1;
    push_acq(p, 0);
    exp_q.push_back(mk(ERROR, 0, 0, 1'b0, p + 62));
    pulse_start(1'b1);
    wait_cyc(p + 70);
    do_stop(0);

    // pass-through, then start+stop together
    p = cyc + 1;
    exp_q.push_back(mk(PASS, 0, 0, 1'b0, p));
    pulse_start(1'b0);
    wait_cyc(p + 5);
    exp_q.push_back(mk(IDLE, 0, 0, 1'b0, cyc + 1));
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk_32m);
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // repeated code loss, relock_cnt saturation
    bus.freq_in = RATE_10K;
    p = cyc + 1;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin
        push_acq(p + 92 * k, k > 15 ? 15 : k);
        exp_q.push_back(mk(LOCKED, k > 15 ? 15 : k, 10,
                           1'b0, p + 92 * k + 42));
      end else begin
        exp_q.push_back(mk(FLUSH, 15, 0, 1'b0,
                           p + 92 * k));
      end
    end
    pulse_start(1'b1);
    wait_cyc(p + 92 * 16 + 2);
    do_stop(15);

    // async reset while acquiring
    p = cyc + 1;
    push_acq(p, 0);
    pulse_start(1'b1);
    wait_cyc(p + 15);
    exp_q.push_back(mk(IDLE, 0, 0, 1'b1, cyc + 1));
    @(posedge clk_32m);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_32m);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_32m);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_entries: got %0d left, required 0",
               exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
